fetch_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch from instruction memory.
- Issues fetch requests and returns fetched instructions to decode.
- Applies redirects from decode/execute. Redirect kinds: jump-register, jump (J-format) and taken branch.
- Sits between the instruction memory port and the decode stage. It is the only writer of PC.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/redirect_target_gen.sv | 39 +++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and field constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // J-format target field and the PC region bits it is spliced into.
    localparam int J_TGT_MSB = 25;
    localparam int J_TGT_LSB = 0;
    localparam int PC_HI_MSB = 31;
    localparam int PC_HI_LSB = 28;

endpackage

// File: rtl/redirect_target_gen.sv
// Combinational redirect target selection: jr > j > br when strobes coincide.
module redirect_target_gen
    import fetch_pkg::*;
(
    input  logic        redir_jr,
    input  logic [31:0] redir_jr_target,
    input  logic        redir_j,
    input  logic [31:0] redir_j_instr,
    input  logic        redir_br,
    input  logic [31:0] redir_br_offset,
    input  logic [31:0] redir_pc4,
    output logic [31:0] target,
    output logic        any_redirect
);

    logic [31:0] j_target;
    logic [31:0] br_target;
    logic        unused_j_opcode;

    assign j_target  = {redir_pc4[PC_HI_MSB:PC_HI_LSB],
                        redir_j_instr[J_TGT_MSB:J_TGT_LSB], 2'b00};
    assign br_target = redir_pc4 + {redir_br_offset[29:0], 2'b00};

    // Opcode bits of the jump word play no part in the target.
    assign unused_j_opcode = ^{redir_j_instr[31:J_TGT_MSB+1], redir_br_offset[31:30]};

    always_comb begin
        target       = 32'h0000_0000;
        any_redirect = redir_jr | redir_j | redir_br;
        if (redir_jr) begin
            target = redir_jr_target;
        end else if (redir_j) begin
            target = j_target;
        end else if (redir_br) begin
            target = br_target;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: issues instruction fetches, delivers instructions to
// decode and applies jr/j/branch redirects, dropping responses they make stale.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc4,
    output logic              instr_valid,
    input  logic              redir_jr,
    input  logic [ADDR_W-1:0] redir_jr_target,
    input  logic              redir_j,
    input  logic [31:0]       redir_j_instr,
    input  logic              redir_br,
    input  logic [31:0]       redir_br_offset,
    input  logic [ADDR_W-1:0] redir_pc4
);

    // Handshake: imem_req/imem_addr are raised from registers and held unchanged
    // until a cycle with imem_ready=1; that cycle transfers imem_rdata and ends
    // the request. stall only gates issue of new requests, never withdraws one.

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              pend_valid, pend_valid_n;
    logic [ADDR_W-1:0] pend_target, pend_target_n;
    logic              deliver;
    logic [ADDR_W-1:0] target;
    logic              any_redirect;
    logic [ADDR_W-1:0] pc_plus4;

    redirect_target_gen u_target (
        .redir_jr        (redir_jr),
        .redir_jr_target (redir_jr_target),
        .redir_j         (redir_j),
        .redir_j_instr   (redir_j_instr),
        .redir_br        (redir_br),
        .redir_br_offset (redir_br_offset),
        .redir_pc4       (redir_pc4),
        .target          (target),
        .any_redirect    (any_redirect)
    );

    assign pc_plus4  = pc + ADDR_W'(4);
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        pend_valid_n  = pend_valid;
        pend_target_n = pend_target;
        deliver       = 1'b0;
        case (state)
            HOLD: begin
                // A redirect while idle only moves the PC; issue waits a cycle.
                if (any_redirect) begin
                    pc_n = target;
                end else if (!stall) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (imem_ready) begin
                    if (any_redirect) begin
                        pc_n = target;
                    end else if (pend_valid) begin
                        pc_n = pend_target;
                    end else begin
                        pc_n    = pc_plus4;
                        deliver = 1'b1;
                    end
                    pend_valid_n = 1'b0;
                    state_n      = stall ? HOLD : REQ;
                end else if (any_redirect) begin
                    pend_valid_n  = 1'b1;
                    pend_target_n = target;
                end
            end
            default: state_n = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HOLD;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            instr_out   <= 32'h0000_0000;
            instr_pc4   <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_valid  <= pend_valid_n;
            pend_target <= pend_target_n;
            instr_valid <= deliver;
            if (deliver) begin
                instr_out <= imem_rdata;
                instr_pc4 <= pc_plus4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer with a transaction-level
// PC model, a delivered-instruction scoreboard and a latency-controlled memory.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc4;
    logic        instr_valid;
    logic        redir_jr = 1'b0;
    logic [31:0] redir_jr_target = 32'h0;
    logic        redir_j = 1'b0;
    logic [31:0] redir_j_instr = 32'h0;
    logic        redir_br = 1'b0;
    logic [31:0] redir_br_offset = 32'h0;
    logic [31:0] redir_pc4 = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    logic [31:0] m_pc = RST_PC;
    logic        m_pend = 1'b0;
    logic [31:0] m_pend_tgt = 32'h0;
    logic        prev_req = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_rst = 1'b1;

    int wait_cnt = 0;
    int cur_lat = 0;
    int fix_lat = 0;
    bit rand_lat = 1'b0;

    fetch_sequencer #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr_out       (instr_out),
        .instr_pc4       (instr_pc4),
        .instr_valid     (instr_valid),
        .redir_jr        (redir_jr),
        .redir_jr_target (redir_jr_target),
        .redir_j         (redir_j),
        .redir_j_instr   (redir_j_instr),
        .redir_br        (redir_br),
        .redir_br_offset (redir_br_offset),
        .redir_pc4       (redir_pc4)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Target from the redirect rules: jr first, then j, then branch.
    function automatic logic [31:0] model_target();
        logic [31:0] pc4;
        logic [31:0] ji;
        pc4 = redir_pc4;
        ji  = redir_j_instr;
        if (redir_jr) return redir_jr_target;
        if (redir_j) return {pc4[31:28], ji[25:0], 2'b00};
        return pc4 + redir_br_offset * 32'd4;
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                wait_cnt   = 0;
                imem_ready = 1'b0;
            end else if (imem_req) begin
                if (wait_cnt == 0) cur_lat = rand_lat ? $urandom_range(0, 3) : fix_lat;
                if (wait_cnt >= cur_lat) begin
                    imem_ready = 1'b1;
                    imem_rdata = $urandom;
                    wait_cnt   = 0;
                end else begin
                    imem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ready = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    always @(negedge clk) begin
        logic        any;
        logic [31:0] t;
        if (rst) begin
            m_pc   = RST_PC;
            m_pend = 1'b0;
        end else begin
            any = redir_jr | redir_j | redir_br;
            t   = model_target();
            check("fetch_addr", imem_addr, m_pc);
            if (!prev_rst && imem_req && !prev_req)
                check("issue_while_stalled", {31'b0, prev_stall}, 32'd0);
            if (!prev_rst && prev_req && !prev_ready)
                check("req_held", {31'b0, imem_req}, 32'd1);
            if (!prev_rst && prev_req && prev_ready)
                check("req_after_accept", {31'b0, imem_req}, {31'b0, ~prev_stall});
            if (imem_req && imem_ready) begin
                if (any) m_pc = t;
                else if (m_pend) m_pc = m_pend_tgt;
                else begin
                    exp_q.push_back({imem_rdata, m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                end
                m_pend = 1'b0;
            end else if (imem_req) begin
                if (any) begin
                    m_pend     = 1'b1;
                    m_pend_tgt = t;
                end
            end else if (any) begin
                m_pc = t;
            end
        end
        prev_req   = imem_req;
        prev_ready = imem_ready;
        prev_stall = stall;
        prev_rst   = rst;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr actual=%h required=none", instr_out);
            end else begin
                e = exp_q.pop_front();
                check("instr_out", instr_out, e[63:32]);
                check("instr_pc4", instr_pc4, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_redir();
        redir_jr = 1'b0;
        redir_j  = 1'b0;
        redir_br = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!imem_req && k < 50) begin tick(); k++; end
        if (!imem_req) timeout_fail(name);
    endtask

    task automatic wait_waiting(input string name);
        int k = 0;
        while (!(imem_req && !imem_ready) && k < 50) begin tick(); k++; end
        if (!(imem_req && !imem_ready)) timeout_fail(name);
    endtask

    task automatic wait_hs(input string name);
        int k = 0;
        while (!(imem_req && imem_ready) && k < 50) begin tick(); k++; end
        if (!(imem_req && imem_ready)) timeout_fail(name);
    endtask

    task automatic go_hold();
        int k = 0;
        stall = 1'b1;
        tick();
        while (imem_req && k < 50) begin tick(); k++; end
        if (imem_req) timeout_fail("go_hold");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] off;
        tick(3);
        rst = 1'b0;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_pc4", instr_pc4, 32'd0);
        tick();
        check("seq_addr0", imem_addr, 32'h0040_0000);
        tick();
        check("seq_addr1", imem_addr, 32'h0040_0004);
        check("seq_pc4_0", instr_pc4, 32'h0040_0004);
        tick();
        check("seq_addr2", imem_addr, 32'h0040_0008);
        check("seq_pc4_1", instr_pc4, 32'h0040_0008);

        // J redirect while idle
        go_hold();
        redir_j = 1'b1; redir_pc4 = 32'h9000_0010; redir_j_instr = 32'h0810_0004;
        tick();
        clear_redir();
        check("j_hold_pc", imem_addr, 32'h9040_0010);
        stall = 1'b0;
        wait_req("j_req");
        check("j_fetch_addr", imem_addr, 32'h9040_0010);

        // Redirects during a 3-cycle memory wait
        go_hold();
        fix_lat = 3;
        stall = 1'b0;
        wait_req("lat_req");
        redir_br = 1'b1; redir_pc4 = 32'h0000_0100; redir_br_offset = 32'hFFFF_FFFE;
        tick();
        clear_redir();
        redir_jr = 1'b1; redir_jr_target = 32'h0000_0200;
        tick();
        clear_redir();
        wait_hs("lat_hs");
        tick();
        check("drop_valid", {31'b0, instr_valid}, 32'd0);
        check("drop_addr", imem_addr, 32'h0000_0200);

        // All three strobes at once
        go_hold();
        fix_lat = 0;
        redir_jr = 1'b1; redir_jr_target = 32'h0000_0300;
        redir_j = 1'b1; redir_j_instr = 32'h0BAD_CAFE; redir_pc4 = 32'h1234_5678;
        redir_br = 1'b1; redir_br_offset = 32'h0000_0010;
        tick();
        clear_redir();
        check("prio_pc", imem_addr, 32'h0000_0300);

        // stall raised while a request waits
        fix_lat = 2;
        stall = 1'b0;
        wait_req("stall_req");
        stall = 1'b1;
        for (int k = 0; k < 10 && !imem_ready; k++) begin
            check("stall_req_held", {31'b0, imem_req}, 32'd1);
            tick();
        end
        tick();
        check("stall_delivered", {31'b0, instr_valid}, 32'd1);
        check("stall_deliv_pc4", instr_pc4, 32'h0000_0304);
        check("stall_hold_req", {31'b0, imem_req}, 32'd0);
        tick();
        check("stall_hold_req2", {31'b0, imem_req}, 32'd0);

        // Reset with a request outstanding
        fix_lat = 3;
        stall = 1'b0;
        wait_waiting("rst_mid_wait");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_req", {31'b0, imem_req}, 32'd0);
        check("rst_mid_addr", imem_addr, RST_PC);
        check("rst_mid_valid", {31'b0, instr_valid}, 32'd0);

        // PC wrap
        fix_lat = 0;
        go_hold();
        redir_jr = 1'b1; redir_jr_target = 32'hFFFF_FFFC;
        tick();
        clear_redir();
        stall = 1'b0;
        wait_hs("wrap_hs");
        tick();
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_pc4", instr_pc4, 32'h0000_0000);

        // Randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            stall           = ($urandom_range(0, 3) == 0);
            redir_jr        = ($urandom_range(0, 14) == 0);
            redir_j         = ($urandom_range(0, 14) == 0);
            redir_br        = ($urandom_range(0, 14) == 0);
            redir_jr_target = $urandom & 32'hFFFF_FFFC;
            redir_j_instr   = $urandom;
            redir_pc4       = $urandom & 32'hFFFF_FFFC;
            off             = $urandom_range(0, 255);
            redir_br_offset = off - 32'd128;
            tick();
        end
        clear_redir();
        go_hold();
        tick(2);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
